// File: rtl/button_event_unit.sv
// -----------------------------------------------------------------------------
// button_event_unit
//
// Push-button input controller for the CPU environment. Each button channel is
// brought into the clk domain by a two-flop synchroniser, normalised so that
// 1 means "pressed", debounced by a per-channel counter and edge-detected.
// Accepted edges are latched into sticky pending flags that the CPU reads and
// clears through a four-word register window. A registered, maskable
// interrupt is raised while any unmasked pending flag is set.
//
// Register window (addr):
//   0 STATUS  (RO)  debounced level of every channel, zero-extended
//   1 PENDING (W1C) sticky event flags; a new event beats a same-cycle clear
//   2 MASK    (RW)  interrupt enable per channel
//   3 COUNT   (RO, any write clears) 8-bit saturating total of events
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   btn_in     in   raw asynchronous button pins [N_BTN]
//   sel        in   CPU access strobe for this block
//   addr       in   register select [2]
//   we         in   write enable, qualified by sel
//   wdata      in   CPU write data [DW]
//   rdata      out  CPU read data, combinational from addr, zero when sel=0
//   irq        out  registered interrupt request
//   btn_level  out  debounced, polarity-normalised level (1 = pressed)
// -----------------------------------------------------------------------------
module button_event_unit #(
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int EDGE_MODE  = 0,
  parameter int DW         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             sel,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  output logic             irq,
  output logic [N_BTN-1:0] btn_level
);

  // Debounce counter must be able to hold DEB_CYCLES-1.
  localparam int              CW       = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(32'd0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(32'd1);

  // Level the pins rest at when nobody touches the buttons.
  localparam logic             IDLE_LEVEL = (ACTIVE_LOW != 32'sd0);
  localparam logic [N_BTN-1:0] IDLE_VEC   = {N_BTN{IDLE_LEVEL}};
  localparam logic [N_BTN-1:0] ZERO_VEC   = {N_BTN{1'b0}};

  // Which transitions of the debounced level count as events.
  localparam logic TAKE_PRESS   = (EDGE_MODE != 32'sd1);
  localparam logic TAKE_RELEASE = (EDGE_MODE != 32'sd0);

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_COUNT   = 2'd3;

  // Number of set bits in an event vector (N_BTN <= 16 fits in 5 bits).
  function automatic logic [4:0] popcount(input logic [N_BTN-1:0] v);
    logic [4:0] total;
    total = 5'd0;
    for (int i = 0; i < N_BTN; i++) begin
      total = total + {4'b0000, v[i]};
    end
    return total;
  endfunction

  // ---------------------------------------------------------------------------
  // Signal declarations
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [N_BTN-1:0] s2_s;
  logic [N_BTN-1:0] stable_r;
  logic [CW-1:0]    cnt_r [N_BTN];

  logic [N_BTN-1:0] differ_s;
  logic [N_BTN-1:0] accept_s;
  logic [N_BTN-1:0] rise_s;
  logic [N_BTN-1:0] fall_s;
  logic [N_BTN-1:0] event_s;

  logic             wr_s;
  logic             wr_pending_s;
  logic             wr_mask_s;
  logic             wr_count_s;
  logic [N_BTN-1:0] clear_s;
  logic [N_BTN-1:0] pending_next_s;

  logic [N_BTN-1:0] pending_r;
  logic [N_BTN-1:0] mask_r;
  logic [7:0]       count_r;
  logic [4:0]       event_pop_s;
  logic [8:0]       count_sum_s;
  logic [7:0]       count_next_s;
  logic             irq_r;

  logic             unused_s;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------

  // Two-stage synchroniser; resets to the idle pin level so no phantom press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= IDLE_VEC;
      sync2_r <= IDLE_VEC;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  // Polarity normalisation: after this XOR, 1 always means pressed.
  assign s2_s = sync2_r ^ IDLE_VEC;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------

  // A channel is accepted when it has differed from stable for DEB_CYCLES samples.
  always_comb begin
    differ_s = ZERO_VEC;
    accept_s = ZERO_VEC;
    for (int i = 0; i < N_BTN; i++) begin
      differ_s[i] = (s2_s[i] != stable_r[i]);
      accept_s[i] = differ_s[i] && (cnt_r[i] == CNT_LAST);
    end
  end

  // Per-channel run-length counter of samples that disagree with stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!differ_s[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (accept_s[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Debounced level: take the synchronised value only on accepted channels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_r <= ZERO_VEC;
    end else begin
      stable_r <= (stable_r & ~accept_s) | (s2_s & accept_s);
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------

  // The accepted value is the new level, so it tells press from release.
  always_comb begin
    rise_s  = accept_s & s2_s;
    fall_s  = accept_s & ~s2_s;
    event_s = (rise_s & {N_BTN{TAKE_PRESS}}) | (fall_s & {N_BTN{TAKE_RELEASE}});
  end

  // ---------------------------------------------------------------------------
  // CPU write decode
  // ---------------------------------------------------------------------------

  // Per-register write strobes and the W1C clear vector.
  always_comb begin
    wr_s         = sel & we;
    wr_pending_s = wr_s && (addr == ADDR_PENDING);
    wr_mask_s    = wr_s && (addr == ADDR_MASK);
    wr_count_s   = wr_s && (addr == ADDR_COUNT);
    if (wr_pending_s) begin
      clear_s = wdata[N_BTN-1:0];
    end else begin
      clear_s = ZERO_VEC;
    end
    // Event is OR-ed after the clear so a fresh event is never lost.
    pending_next_s = (pending_r & ~clear_s) | event_s;
  end

  // Only the low N_BTN data bits are meaningful for this block's registers.
  generate
    if (DW > N_BTN) begin : g_wdata_hi
      assign unused_s = ^wdata[DW-1:N_BTN];
    end else begin : g_wdata_full
      assign unused_s = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Sticky pending flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= ZERO_VEC;
    end else begin
      pending_r <= pending_next_s;
    end
  end

  // Interrupt mask, written directly by the CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r <= ZERO_VEC;
    end else if (wr_mask_s) begin
      mask_r <= wdata[N_BTN-1:0];
    end else begin
      mask_r <= mask_r;
    end
  end

  // Next event total: saturating add, or restart from this cycle's events on write.
  always_comb begin
    event_pop_s = popcount(event_s);
    count_sum_s = {1'b0, count_r} + {4'b0000, event_pop_s};
    if (wr_count_s) begin
      count_next_s = {3'b000, event_pop_s};
    end else if (count_sum_s[8]) begin
      count_next_s = 8'hFF;
    end else begin
      count_next_s = count_sum_s[7:0];
    end
  end

  // Event counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 8'h00;
    end else begin
      count_r <= count_next_s;
    end
  end

  // Registered interrupt: one cycle behind pending and mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(pending_r & mask_r);
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------

  // Combinational read data; unused upper bits and unselected cycles read 0.
  always_comb begin
    rdata = {DW{1'b0}};
    if (sel) begin
      case (addr)
        ADDR_STATUS:  rdata[N_BTN-1:0] = stable_r;
        ADDR_PENDING: rdata[N_BTN-1:0] = pending_r;
        ADDR_MASK:    rdata[N_BTN-1:0] = mask_r;
        ADDR_COUNT:   rdata[7:0]       = count_r;
        default:      rdata            = {DW{1'b0}};
      endcase
    end else begin
      rdata = {DW{1'b0}};
    end
  end

  assign irq       = irq_r;
  assign btn_level = stable_r;

endmodule

// File: tb/tb_button_event_unit.sv
// Self-checking bench for button_event_unit.
// u_dut_a (press events) runs a cycle table and directed sequences;
// u_dut_b (both edges) runs the release case and a randomized run against
// a sample-window reference model.
module tb_button_event_unit;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  btn_a, btn_b;
  logic        sel_a, we_a, sel_b, we_b;
  logic [1:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic [15:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;
  logic [3:0]  lvl_a, lvl_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_event_unit #(.N_BTN(4), .DEB_CYCLES(DEB), .ACTIVE_LOW(1), .EDGE_MODE(0), .DW(16)) u_dut_a (
    .clk(clk), .reset(reset), .btn_in(btn_a), .sel(sel_a), .addr(addr_a), .we(we_a),
    .wdata(wdata_a), .rdata(rdata_a), .irq(irq_a), .btn_level(lvl_a));

  button_event_unit #(.N_BTN(4), .DEB_CYCLES(DEB), .ACTIVE_LOW(1), .EDGE_MODE(2), .DW(16)) u_dut_b (
    .clk(clk), .reset(reset), .btn_in(btn_b), .sel(sel_b), .addr(addr_b), .we(we_b),
    .wdata(wdata_b), .rdata(rdata_b), .irq(irq_b), .btn_level(lvl_b));

  typedef struct {
    logic [3:0]  btn;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_irq;
    logic [3:0]  exp_lvl;
  } vec_t;

  vec_t tbl [12];

  // ---------------- reference model state (for u_dut_b) ----------------
  logic [3:0] m_hist [$];
  logic [3:0] m_stable, m_pending, m_mask;
  int         m_count;
  logic       m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reg_a(input string name, input logic [1:0] a, input logic [15:0] exp);
    sel_a = 1'b1; we_a = 1'b0; addr_a = a;
    #1;
    check(name, {16'h0, rdata_a}, {16'h0, exp});
    sel_a = 1'b0;
  endtask

  task automatic check_reg_b(input string name, input logic [1:0] a, input logic [15:0] exp);
    sel_b = 1'b1; we_b = 1'b0; addr_b = a;
    #1;
    check(name, {16'h0, rdata_b}, {16'h0, exp});
    sel_b = 1'b0;
  endtask

  // One CPU write on u_dut_a, taking effect at the next rising edge.
  task automatic write_a(input logic [1:0] a, input logic [15:0] d);
    sel_a = 1'b1; we_a = 1'b1; addr_a = a; wdata_a = d;
    @(negedge clk);
    sel_a = 1'b0; we_a = 1'b0; wdata_a = 16'h0;
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < DEB + 2; i++) m_hist.push_back(4'h0);
    m_stable = 4'h0; m_pending = 4'h0; m_mask = 4'h0; m_count = 0; m_irq = 1'b0;
  endtask

  // One rising edge of the model. A channel flips when the DEB pressed-samples
  // that have reached the debouncer (pins seen 2..DEB+1 edges ago) all disagree
  // with the current stable level.
  task automatic model_step();
    logic [3:0] flips, ev;
    logic       all_diff, wr;
    int         pop;
    m_hist.push_back(~btn_b);
    while (m_hist.size() > DEB + 2) void'(m_hist.pop_front());
    flips = 4'h0;
    for (int ch = 0; ch < 4; ch++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) if (m_hist[j][ch] == m_stable[ch]) all_diff = 1'b0;
      flips[ch] = all_diff;
    end
    ev = flips;  // both edges count for u_dut_b
    wr = sel_b && we_b;
    m_irq = |(m_pending & m_mask);
    if (wr && addr_b == 2'd1) m_pending = m_pending & ~wdata_b[3:0];
    m_pending = m_pending | ev;
    if (wr && addr_b == 2'd2) m_mask = wdata_b[3:0];
    pop = $countones(ev);
    if (wr && addr_b == 2'd3) m_count = pop;
    else m_count = (m_count + pop > 255) ? 255 : m_count + pop;
    m_stable = m_stable ^ flips;
  endtask

  function automatic logic [15:0] model_rdata();
    if (!sel_b) return 16'h0;
    case (addr_b)
      2'd0:    return {12'h0, m_stable};
      2'd1:    return {12'h0, m_pending};
      2'd2:    return {12'h0, m_mask};
      default: return {8'h0, 8'(m_count)};
    endcase
  endfunction

  initial begin
    // Clean-press cycle table; record k is driven just after edge k.
    tbl[0]  = '{4'hE, 1'b1, 1'b1, 2'd2, 16'h0001, 16'h0000, 1'b0, 4'h0};
    tbl[1]  = '{4'hE, 1'b1, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 4'h0};
    tbl[2]  = '{4'hE, 1'b1, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 4'h0};
    tbl[3]  = '{4'hE, 1'b1, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 4'h0};
    tbl[4]  = '{4'hE, 1'b1, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 4'h0};
    tbl[5]  = '{4'hE, 1'b1, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 4'h0};
    tbl[6]  = '{4'hE, 1'b1, 1'b0, 2'd1, 16'h0000, 16'h0001, 1'b0, 4'h1};
    tbl[7]  = '{4'hE, 1'b1, 1'b0, 2'd0, 16'h0000, 16'h0001, 1'b1, 4'h1};
    tbl[8]  = '{4'hE, 1'b1, 1'b0, 2'd3, 16'h0000, 16'h0001, 1'b1, 4'h1};
    tbl[9]  = '{4'hE, 1'b1, 1'b1, 2'd1, 16'h0001, 16'h0001, 1'b1, 4'h1};
    tbl[10] = '{4'hE, 1'b1, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b1, 4'h1};
    tbl[11] = '{4'hE, 1'b1, 1'b0, 2'd2, 16'h0000, 16'h0001, 1'b0, 4'h1};

    reset = 1'b0;
    btn_a = 4'hF; sel_a = 1'b0; we_a = 1'b0; addr_a = 2'd0; wdata_a = 16'h0;
    btn_b = 4'hF; sel_b = 1'b0; we_b = 1'b0; addr_b = 2'd0; wdata_b = 16'h0;
    step(3);
    reset = 1'b1;
    step(20);

    // Reset / idle
    check_reg_a("idle_status", 2'd0, 16'h0);
    check_reg_a("idle_pending", 2'd1, 16'h0);
    check_reg_a("idle_mask", 2'd2, 16'h0);
    check_reg_a("idle_count", 2'd3, 16'h0);
    check("idle_irq", {31'h0, irq_a}, 32'h0);
    check("idle_level", {28'h0, lvl_a}, 32'h0);

    // Clean press, table driven
    for (int k = 0; k < 12; k++) begin
      btn_a = tbl[k].btn; sel_a = tbl[k].sel; we_a = tbl[k].we;
      addr_a = tbl[k].addr; wdata_a = tbl[k].wdata;
      #1;
      check($sformatf("tbl%0d_rdata", k), {16'h0, rdata_a}, {16'h0, tbl[k].exp_rdata});
      check($sformatf("tbl%0d_irq", k), {31'h0, irq_a}, {31'h0, tbl[k].exp_irq});
      check($sformatf("tbl%0d_level", k), {28'h0, lvl_a}, {28'h0, tbl[k].exp_lvl});
      @(negedge clk);
    end
    sel_a = 1'b0; we_a = 1'b0; wdata_a = 16'h0;

    // Glitch rejection: channel 1 low for 3 cycles only
    btn_a = 4'hC;
    step(3);
    btn_a = 4'hE;
    for (int k = 0; k < 10; k++) begin
      check("glitch_irq", {31'h0, irq_a}, 32'h0);
      step(1);
    end
    check_reg_a("glitch_status", 2'd0, 16'h0001);
    check_reg_a("glitch_pending", 2'd1, 16'h0000);
    check_reg_a("glitch_count", 2'd3, 16'h0001);
    sel_a = 1'b0; addr_a = 2'd0; #1;
    check("unselected_rdata", {16'h0, rdata_a}, 32'h0);

    // Masking and simultaneous events
    btn_a = 4'hF;
    step(10);
    write_a(2'd3, 16'h0);
    write_a(2'd2, 16'h0);
    btn_a = 4'h0;
    step(10);
    check_reg_a("simul_pending", 2'd1, 16'h000F);
    check_reg_a("simul_count", 2'd3, 16'h0004);
    check("masked_irq", {31'h0, irq_a}, 32'h0);
    write_a(2'd2, 16'h0004);
    check("mask_irq_not_early", {31'h0, irq_a}, 32'h0);
    step(1);
    check("mask_irq", {31'h0, irq_a}, 32'h1);

    // Set-vs-clear race on channel 2
    write_a(2'd1, 16'h000F);
    write_a(2'd2, 16'h0000);
    btn_a = 4'hF;
    step(10);
    check_reg_a("race_pre_pending", 2'd1, 16'h0);
    btn_a = 4'hB;
    step(5);
    sel_a = 1'b1; we_a = 1'b1; addr_a = 2'd1; wdata_a = 16'h0004;
    step(1);   // edge 6: event and clear together
    sel_a = 1'b0; we_a = 1'b0; wdata_a = 16'h0;
    check_reg_a("race_pending", 2'd1, 16'h0004);
    check_reg_a("race_count", 2'd3, 16'h0005);
    write_a(2'd1, 16'h0004);
    check_reg_a("w1c_pending", 2'd1, 16'h0000);

    // Saturation: 3 + 63*4 more events on top of 5
    for (int it = 0; it < 64; it++) begin
      btn_a = 4'h0; step(8);
      btn_a = 4'hF; step(8);
      if (it == 29) check_reg_a("count_mid", 2'd3, 16'd124);
    end
    check_reg_a("count_sat", 2'd3, 16'd255);
    btn_a = 4'h0; step(8);
    btn_a = 4'hF; step(8);
    check_reg_a("count_stay_sat", 2'd3, 16'd255);
    write_a(2'd3, 16'hFFFF);
    check_reg_a("count_clear", 2'd3, 16'h0);

    // Both-edge mode: press then release channel 3
    btn_b = 4'h7; step(10);
    btn_b = 4'hF; step(10);
    check_reg_b("both_count", 2'd3, 16'h0002);
    check_reg_b("both_pending", 2'd1, 16'h0008);

    // Reset in the middle of a debounce
    btn_a = 4'hE;
    step(4);
    reset = 1'b0;
    check_reg_a("rst_status", 2'd0, 16'h0);
    check_reg_a("rst_pending", 2'd1, 16'h0);
    check_reg_a("rst_mask", 2'd2, 16'h0);
    check_reg_a("rst_count", 2'd3, 16'h0);
    check("rst_irq", {31'h0, irq_a}, 32'h0);
    step(2);
    reset = 1'b1;
    step(DEB + 1);
    check_reg_a("rerun_pending_early", 2'd1, 16'h0);
    step(1);
    check_reg_a("rerun_pending", 2'd1, 16'h0001);
    check("rerun_level", {28'h0, lvl_a}, 32'h1);

    // Randomized run of u_dut_b against the reference model
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(7) == 0) begin
        int ch;
        ch = $urandom_range(3);
        btn_b[ch] = ~btn_b[ch];
      end
      sel_b   = 1'($urandom_range(1));
      we_b    = ($urandom_range(3) == 0);
      addr_b  = 2'($urandom_range(3));
      wdata_b = 16'($urandom);
      #1;
      check("rand_rdata", {16'h0, rdata_b}, {16'h0, model_rdata()});
      check("rand_irq", {31'h0, irq_b}, {31'h0, m_irq});
      check("rand_level", {28'h0, lvl_b}, {28'h0, m_stable});
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
